// File: rtl/iter_div_unit_if.sv
// Divide request/response interface between the execute stage (master) and
// the iterative divider (slave).
interface iter_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             accept;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_div, dividend, divisor, accept, cancel,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  start, signed_div, dividend, divisor, accept, cancel,
        output busy, done, quotient, remainder
    );
endinterface

// File: rtl/iter_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: quotient to LO, remainder to HI.
// Optional early completion for |dividend| < |divisor| under ITER_DIV_EARLY_OUT_EN.
module iter_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    iter_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? neg_val(v) : v;
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic             q_neg_r;
    logic             r_neg_r;
    logic             zero_div_r;
    logic             skip_fix_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] next_rem_s;
    logic [WIDTH-1:0] next_dvd_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;
    logic             early_s;

    // Operand magnitudes, one restoring step, and final sign correction.
    always_comb begin
        mag_a_s = mag_of(bus.dividend, bus.signed_div);
        mag_b_s = mag_of(bus.divisor, bus.signed_div);
        shift_s = {rem_r, dvd_r[WIDTH-1]};
        trial_s = shift_s - {1'b0, dsr_r};
        if (trial_s[WIDTH]) begin
            next_rem_s = shift_s[WIDTH-1:0];
            next_dvd_s = {dvd_r[WIDTH-2:0], 1'b0};
        end else begin
            next_rem_s = trial_s[WIDTH-1:0];
            next_dvd_s = {dvd_r[WIDTH-2:0], 1'b1};
        end
        // Divide-by-zero keeps the all-ones quotient regardless of operand signs.
        if (q_neg_r && !zero_div_r && !skip_fix_r) begin
            q_fix_s = neg_val(dvd_r);
        end else begin
            q_fix_s = dvd_r;
        end
        if (r_neg_r && !skip_fix_r) begin
            r_fix_s = neg_val(rem_r);
        end else begin
            r_fix_s = rem_r;
        end
`ifdef ITER_DIV_EARLY_OUT_EN
        early_s = (mag_a_s < mag_b_s) && (mag_b_s != {WIDTH{1'b0}});
`else
        early_s = 1'b0;
`endif
    end

    // Divider control FSM with registered status and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            dvd_r       <= {WIDTH{1'b0}};
            dsr_r       <= {WIDTH{1'b0}};
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            zero_div_r  <= 1'b0;
            skip_fix_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        dsr_r      <= mag_b_s;
                        q_neg_r    <= bus.signed_div & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_neg_r    <= bus.signed_div & bus.dividend[WIDTH-1];
                        zero_div_r <= (bus.divisor == {WIDTH{1'b0}});
                        cnt_r      <= {CNT_W{1'b0}};
                        busy_r     <= 1'b1;
                        if (early_s) begin
                            rem_r      <= bus.dividend;
                            dvd_r      <= {WIDTH{1'b0}};
                            skip_fix_r <= 1'b1;
                            state_r    <= ST_SIGN;
                        end else begin
                            rem_r      <= {WIDTH{1'b0}};
                            dvd_r      <= mag_a_s;
                            skip_fix_r <= 1'b0;
                            state_r    <= ST_CALC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (bus.cancel) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        rem_r <= next_rem_s;
                        dvd_r <= next_dvd_s;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(WIDTH - 1)) begin
                            state_r <= ST_SIGN;
                        end else begin
                            state_r <= ST_CALC;
                        end
                    end
                end
                ST_SIGN: begin
                    busy_r <= 1'b0;
                    if (bus.cancel) begin
                        state_r <= ST_IDLE;
                    end else begin
                        quotient_r  <= q_fix_s;
                        remainder_r <= r_fix_s;
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.cancel || bus.accept) begin
                        done_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: scoreboard of expected results,
// one task per scenario.
module tb_iter_div_unit;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    res_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    iter_div_unit_if div_if ();

    iter_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (div_if)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        res_t res;
        if (b == 32'd0) begin
            res.q = 32'hFFFF_FFFF;
            res.r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res.q = 32'h8000_0000;
            res.r = 32'd0;
        end else if (s) begin
            res.q = 32'($signed(a) / $signed(b));
            res.r = 32'($signed(a) % $signed(b));
        end else begin
            res.q = a / b;
            res.r = a % b;
        end
        return res;
    endfunction

    // Called at a negedge (cycle 0); returns at the negedge of cycle 1 with start low.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_q.push_back(model(a, b, s));
        div_if.dividend   = a;
        div_if.divisor    = b;
        div_if.signed_div = s;
        div_if.start      = 1'b1;
        @(negedge clk);
        div_if.start = 1'b0;
    endtask

    task automatic wait_done(input int first, output int cyc, output logic [31:0] q,
                             output logic [31:0] r, output logic to);
        cyc = first;
        to  = 1'b1;
        q   = 32'd0;
        r   = 32'd0;
        for (int i = 0; i < 100; i++) begin
            if (div_if.done === 1'b1) begin
                to = 1'b0;
                q  = div_if.quotient;
                r  = div_if.remainder;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        div_if.start = 1'b0; div_if.signed_div = 1'b0; div_if.accept = 1'b0;
        div_if.cancel = 1'b0; div_if.dividend = 32'd0; div_if.divisor = 32'd0;
        repeat (2) @(negedge clk);
        tests_run++; if (div_if.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", div_if.done); end
        tests_run++; if (div_if.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", div_if.busy); end
        tests_run++; if (div_if.quotient !== 32'd0) begin tests_failed++; $display("FAIL reset_q got %h want 0", div_if.quotient); end
        tests_run++; if (div_if.remainder !== 32'd0) begin tests_failed++; $display("FAIL reset_r got %h want 0", div_if.remainder); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_case(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input int lat);
        int cyc; logic [31:0] q, r; logic to; res_t e;
        launch(a, b, s);
        tests_run++; if (div_if.busy !== 1'b1) begin tests_failed++; $display("FAIL %s_busy got %b want 1", name, div_if.busy); end
        wait_done(1, cyc, q, r, to);
        e = exp_q.pop_front();
        tests_run++; if (to) begin tests_failed++; $display("FAIL %s_timeout done never rose", name); end
        tests_run++; if (cyc != lat) begin tests_failed++; $display("FAIL %s_latency got %0d want %0d", name, cyc, lat); end
        tests_run++; if (q !== e.q) begin tests_failed++; $display("FAIL %s_q got %h want %h", name, q, e.q); end
        tests_run++; if (r !== e.r) begin tests_failed++; $display("FAIL %s_r got %h want %h", name, r, e.r); end
        @(negedge clk);
        tests_run++; if (div_if.done !== 1'b0 || div_if.busy !== 1'b0) begin tests_failed++; $display("FAIL %s_idle got done=%b busy=%b want 0/0", name, div_if.done, div_if.busy); end
    endtask

    task automatic test_divu_basic();
        div_if.accept = 1'b1;
        run_case("divu_100_7", 32'd100, 32'd7, 1'b0, 34);
        run_case("divu_big", 32'hFFFF_FFFF, 32'd3, 1'b0, 34);
    endtask

    task automatic test_signed();
        div_if.accept = 1'b1;
        run_case("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 34);
        run_case("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 34);
        run_case("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 34);
    endtask

    task automatic test_div_zero();
        div_if.accept = 1'b1;
        run_case("divu_zero", 32'h1234_5678, 32'd0, 1'b0, 34);
        run_case("div_neg_zero", 32'hFFFF_FFFB, 32'd0, 1'b1, 34);
    endtask

    task automatic test_hold();
        int cyc; logic [31:0] q, r; logic to; res_t e; int bad;
        div_if.accept = 1'b0;
        launch(32'd50, 32'd5, 1'b0);
        wait_done(1, cyc, q, r, to);
        e = exp_q.pop_front();
        tests_run++; if (to || cyc != 34) begin tests_failed++; $display("FAIL hold_latency got %0d want 34", cyc); end
        tests_run++; if (q !== e.q || r !== e.r) begin tests_failed++; $display("FAIL hold_result got %h/%h want %h/%h", q, r, e.q, e.r); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            div_if.start = i[0];
            div_if.dividend = $urandom;
            div_if.divisor = $urandom;
            @(negedge clk);
            if (div_if.done !== 1'b1 || div_if.quotient !== 32'd10 || div_if.remainder !== 32'd0) bad++;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL hold_stable got %0d unstable cycles want 0", bad); end
        div_if.start = 1'b0;
        div_if.accept = 1'b1;
        @(negedge clk);
        tests_run++; if (div_if.done !== 1'b0) begin tests_failed++; $display("FAIL hold_accept got done=%b want 0", div_if.done); end
        @(negedge clk);
        tests_run++; if (div_if.busy !== 1'b0) begin tests_failed++; $display("FAIL hold_no_restart got busy=%b want 0", div_if.busy); end
    endtask

    task automatic test_cancel();
        int seen;
        div_if.accept = 1'b1;
        launch(32'd1000, 32'd3, 1'b0);
        void'(exp_q.pop_front());
        repeat (14) @(negedge clk);
        div_if.cancel = 1'b1;
        @(negedge clk);
        div_if.cancel = 1'b0;
        tests_run++; if (div_if.busy !== 1'b0) begin tests_failed++; $display("FAIL cancel_busy got %b want 0", div_if.busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_if.done !== 1'b0) seen++;
        end
        tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL cancel_done got %0d done cycles want 0", seen); end
        tests_run++; if (div_if.quotient !== 32'd10 || div_if.remainder !== 32'd0) begin tests_failed++; $display("FAIL cancel_outputs got %h/%h want 0000000a/00000000", div_if.quotient, div_if.remainder); end
        run_case("after_cancel_9_3", 32'd9, 32'd3, 1'b0, 34);
    endtask

    task automatic test_reset_mid();
        div_if.accept = 1'b1;
        launch(32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
        void'(exp_q.pop_front());
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++; if (div_if.busy !== 1'b0 || div_if.done !== 1'b0) begin tests_failed++; $display("FAIL midreset_status got busy=%b done=%b want 0/0", div_if.busy, div_if.done); end
        tests_run++; if (div_if.quotient !== 32'd0 || div_if.remainder !== 32'd0) begin tests_failed++; $display("FAIL midreset_outputs got %h/%h want 0/0", div_if.quotient, div_if.remainder); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_small_dividend();
        int lat;
`ifdef ITER_DIV_EARLY_OUT_EN
        lat = 2;
`else
        lat = 34;
`endif
        div_if.accept = 1'b1;
        run_case("divu_3_10", 32'd3, 32'd10, 1'b0, lat);
        run_case("div_m3_10", 32'hFFFF_FFFD, 32'd10, 1'b1, lat);
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_hold();
        test_cancel();
        test_reset_mid();
        test_small_dividend();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
